// File: rtl/freq_readout_streamer.sv
// Streams two 8-column frequency lines ("ddddd Hz") as ASCII characters from a snapshot.
// Optional leading-zero blanking is enabled by defining FREQ_READOUT_ZERO_BLANK_EN.
module freq_readout_streamer #(
  parameter logic [6:0] SPACE_CODE = 7'h20,
  parameter logic [6:0] ERR_CODE   = 7'h3F
) (
  input  logic        Main_CLK,
  input  logic        Main_RST_n,
  input  logic        Refresh,
  input  logic [19:0] CH1_BCD,
  input  logic [19:0] CH2_BCD,
  input  logic        Char_Ready,
  output logic        Char_Valid,
  output logic [6:0]  Char_Code,
  output logic        Char_Row,
  output logic [2:0]  Char_Col,
  output logic        Busy,
  output logic        Frame_Done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic        pending, pending_nxt;
  logic [19:0] snap1, snap1_nxt;
  logic [19:0] snap2, snap2_nxt;
  logic        take;

  always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
    if (!Main_RST_n) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      snap1   <= '0;
      snap2   <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
      snap1   <= snap1_nxt;
      snap2   <= snap2_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pending_nxt = pending;
    snap1_nxt   = snap1;
    snap2_nxt   = snap2;
    take        = 1'b0;
    case (state)
      IDLE: begin
        if (Refresh) begin
          take      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (Refresh) pending_nxt = 1'b1;
        if (Char_Ready) begin
          idx_nxt = idx + 4'd1;
          if (idx == 4'd15) state_nxt = DONE;
        end
      end
      DONE: begin
        // A Refresh landing in DONE itself counts as pending and chains directly.
        if (pending || Refresh) begin
          take      = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      snap1_nxt   = CH1_BCD;
      snap2_nxt   = CH2_BCD;
      idx_nxt     = '0;
      pending_nxt = 1'b0;
    end
  end

  logic [19:0] row_bcd;
  logic [3:0]  digit;
  logic [3:0]  lead_zero;
  logic        blank;

  always_comb begin
    row_bcd = idx[3] ? snap2 : snap1;
    lead_zero[0] = (row_bcd[19:16] == 4'd0);
    lead_zero[1] = lead_zero[0] && (row_bcd[15:12] == 4'd0);
    lead_zero[2] = lead_zero[1] && (row_bcd[11:8] == 4'd0);
    lead_zero[3] = lead_zero[2] && (row_bcd[7:4] == 4'd0);
    case (idx[2:0])
      3'd0:    digit = row_bcd[19:16];
      3'd1:    digit = row_bcd[15:12];
      3'd2:    digit = row_bcd[11:8];
      3'd3:    digit = row_bcd[7:4];
      default: digit = row_bcd[3:0];
    endcase
`ifdef FREQ_READOUT_ZERO_BLANK_EN
    blank = (idx[2:0] < 3'd4) && lead_zero[idx[1:0]];
`else
    blank = 1'b0;
`endif
  end

  always_comb begin
    Char_Valid = (state == SEND);
    Busy       = (state != IDLE);
    Frame_Done = (state == DONE);
    Char_Code  = '0;
    Char_Row   = 1'b0;
    Char_Col   = '0;
    if (state == SEND) begin
      Char_Row = idx[3];
      Char_Col = idx[2:0];
      case (idx[2:0])
        3'd5:    Char_Code = SPACE_CODE;
        3'd6:    Char_Code = 7'h48;
        3'd7:    Char_Code = 7'h7A;
        default: begin
          if (blank)            Char_Code = SPACE_CODE;
          else if (digit > 4'd9) Char_Code = ERR_CODE;
          else                  Char_Code = 7'h30 + {3'b000, digit};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_readout_streamer.sv
// Scoreboard bench for freq_readout_streamer; expectations follow FREQ_READOUT_ZERO_BLANK_EN.
module tb_freq_readout_streamer;

  logic        Main_CLK = 1'b0;
  logic        Main_RST_n;
  logic        Refresh;
  logic [19:0] CH1_BCD, CH2_BCD;
  logic        Char_Ready;
  logic        Char_Valid;
  logic [6:0]  Char_Code;
  logic        Char_Row;
  logic [2:0]  Char_Col;
  logic        Busy;
  logic        Frame_Done;

  freq_readout_streamer #(.SPACE_CODE(7'h20), .ERR_CODE(7'h3F)) dut (
    .Main_CLK   (Main_CLK),
    .Main_RST_n (Main_RST_n),
    .Refresh    (Refresh),
    .CH1_BCD    (CH1_BCD),
    .CH2_BCD    (CH2_BCD),
    .Char_Ready (Char_Ready),
    .Char_Valid (Char_Valid),
    .Char_Code  (Char_Code),
    .Char_Row   (Char_Row),
    .Char_Col   (Char_Col),
    .Busy       (Busy),
    .Frame_Done (Frame_Done)
  );

  always #5 Main_CLK = ~Main_CLK;

  typedef struct packed {
    logic [6:0] code;
    logic       row;
    logic [2:0] col;
  } chr_t;

  chr_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_char(input logic [19:0] bcd, input int unsigned col);
    logic [3:0] d;
    bit lead;
    if (col == 5) return 7'h20;
    if (col == 6) return 7'h48;
    if (col == 7) return 7'h7A;
    lead = 1'b1;
    d = '0;
    for (int unsigned k = 0; k <= col; k++) begin
      d = 4'(bcd >> (4 * (4 - k)));
      if (d != 4'd0) lead = 1'b0;
    end
    if (d > 4'd9) return 7'h3F;
`ifdef FREQ_READOUT_ZERO_BLANK_EN
    if (lead && col < 4) return 7'h20;
`endif
    return 7'h30 + {3'b000, d};
  endfunction

  task automatic push_frame(input logic [19:0] c1, input logic [19:0] c2);
    for (int r = 0; r < 2; r++)
      for (int unsigned c = 0; c < 8; c++)
        q.push_back({exp_char((r == 1) ? c2 : c1, c), 1'(r), 3'(c)});
  endtask

  task automatic refresh(input logic [19:0] c1, input logic [19:0] c2);
    @(posedge Main_CLK); #1;
    CH1_BCD = c1;
    CH2_BCD = c2;
    Refresh = 1'b1;
    push_frame(c1, c2);
    @(negedge Main_CLK);
    check("idle_busy", Busy, 0);
    check("idle_valid", Char_Valid, 0);
    @(posedge Main_CLK); #1;
    Refresh = 1'b0;
  endtask

  task automatic wait_frame(input int stall_at, input int stall_len, input bit extra, input bit b2b);
    int cyc = 0, acc = 0, last = -100, stalls = 0, pulses = 0;
    bit done = 1'b0;
    chr_t e;
    while (!done && cyc < 300) begin
      @(negedge Main_CLK);
      cyc++;
      if (b2b && cyc == 1) check("b2b_start", Char_Valid, 1);
      if (Frame_Done) begin
        check("done_timing", cyc, last + 1);
        check("done_valid", Char_Valid, 0);
        check("done_busy", Busy, 1);
        check("done_count", acc, 16);
        check("frame_cycles", cyc, 17 + stall_len);
        done = 1'b1;
      end else if (Char_Valid) begin
        check("busy_send", Busy, 1);
        if (q.size() == 0) begin
          check("extra_char", q.size(), 1);
        end else begin
          e = q[0];
          check("char", {Char_Code, Char_Row, Char_Col}, e);
          if (Char_Ready) begin
            void'(q.pop_front());
            acc++;
            last = cyc;
          end
        end
      end else begin
        check("valid_gap", Char_Valid, 1);
      end
      if (!done) begin
        @(posedge Main_CLK); #1;
        Refresh = 1'b0;
        if (extra && (acc == 4 || acc == 6 || acc == 8)) begin
          Refresh = 1'b1;
          if (pulses == 0) push_frame(CH1_BCD, CH2_BCD);
          pulses++;
        end
        if (acc == stall_at && stalls < stall_len) begin
          Char_Ready = 1'b0;
          stalls++;
          CH1_BCD = 20'($urandom);
        end else begin
          Char_Ready = 1'b1;
        end
      end
    end
    if (!done) check("frame_timeout", done, 1);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Main_CLK);
      check("idle_quiet", {Frame_Done, Busy, Char_Valid}, 0);
    end
  endtask

  initial begin
    chr_t e;
    Main_RST_n = 1'b0;
    Refresh    = 1'b0;
    Char_Ready = 1'b1;
    CH1_BCD    = '0;
    CH2_BCD    = '0;
    #2;
    check("rst_outputs", {Char_Valid, Busy, Frame_Done, Char_Code, Char_Row, Char_Col}, 0);
    repeat (2) @(posedge Main_CLK);
    #1 Main_RST_n = 1'b1;
    idle_check(3);

    refresh(20'h01234, 20'h00050);
    wait_frame(-1, 0, 1'b0, 1'b0);

    refresh(20'h00000, 20'h0A123);
    wait_frame(-1, 0, 1'b0, 1'b0);

    // Stall at index 3 while CH1 is scrambled; stream must still show the snapshot.
    refresh(20'h01234, 20'h00050);
    wait_frame(3, 5, 1'b0, 1'b0);
    CH1_BCD = 20'h00987;

    // Three Refresh pulses mid-frame merge into one back-to-back frame.
    refresh(20'h00987, 20'h09999);
    wait_frame(-1, 0, 1'b1, 1'b0);
    wait_frame(-1, 0, 1'b0, 1'b1);
    idle_check(4);

    // Reset while index 9 is presented.
    @(posedge Main_CLK); #1;
    CH1_BCD = 20'h12345;
    CH2_BCD = 20'h67890;
    Refresh = 1'b1;
    push_frame(CH1_BCD, CH2_BCD);
    @(posedge Main_CLK); #1;
    Refresh = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge Main_CLK);
      e = q.pop_front();
      check("pre_rst_char", {Char_Code, Char_Row, Char_Col}, e);
    end
    @(negedge Main_CLK);
    check("rst_at_idx9", {Char_Valid, Char_Row, Char_Col}, 5'b11001);
    #1 Main_RST_n = 1'b0;
    #1;
    check("rst_async", {Char_Valid, Busy, Frame_Done, Char_Code, Char_Row, Char_Col}, 0);
    q.delete();
    repeat (2) @(posedge Main_CLK);
    #1 Main_RST_n = 1'b1;
    idle_check(20);

    refresh(20'h12345, 20'h0FFFF);
    wait_frame(-1, 0, 1'b0, 1'b0);
    check("q_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/freq_readout_streamer.md
FREQ_READOUT_STREAMER -- requirements
Module: freq_readout_streamer

Interface
REQ-001 Parameter SPACE_CODE, default 7'h20: character code emitted for a blanked digit and for the separator.
REQ-002 Parameter ERR_CODE, default 7'h3F: character code emitted for a BCD nibble greater than 9.
REQ-003 Main_CLK  in  1: the single clock; all state changes on its rising edge.
REQ-004 Main_RST_n  in  1: reset, asynchronous and active-low.
REQ-005 Refresh  in  1: one-cycle request to take a new snapshot and stream one frame.
REQ-006 CH1_BCD  in  20: channel 1 frequency, 5 BCD digits, [19:16] most significant.
REQ-007 CH2_BCD  in  20: channel 2 frequency, same format.
REQ-008 Char_Ready  in  1: the downstream text writer accepts the current character.
REQ-009 Char_Valid  out  1: Char_Code, Char_Row and Char_Col are valid.
REQ-010 Char_Code  out  7: ASCII character.
REQ-011 Char_Row  out  1: 0 = channel 1 line, 1 = channel 2 line.
REQ-012 Char_Col  out  3: column 0..7 within the line.
REQ-013 Busy  out  1: high from snapshot until the frame completes.
REQ-014 Frame_Done  out  1: one-cycle pulse after the last character is accepted.

Function
REQ-015 The FSM SHALL have states IDLE, SEND and DONE.
REQ-016 IDLE: Refresh=1 SHALL register CH1_BCD/CH2_BCD into snapshot registers, zero the 4-bit index, and enter SEND on the next edge. Busy rises in the same cycle as Char_Valid.
REQ-017 SEND: Char_Valid SHALL be 1, and Char_Code, Char_Row and Char_Col SHALL decode registered state only, with no combinational path from Char_Ready.
REQ-018 The outputs SHALL hold stable while Char_Valid=1 and Char_Ready=0.
REQ-019 When Char_Valid and Char_Ready are both 1 on an edge, the index SHALL increment.
REQ-020 Acceptance of index 15 SHALL move the FSM to DONE.
REQ-021 Index mapping: Char_Row=index[3] and Char_Col=index[2:0].
REQ-022 Columns 0-4 SHALL carry digits [19:16]..[3:0] of the row's snapshot.
REQ-023 Column 5 SHALL carry SPACE_CODE, column 6 SHALL carry 'H' (7'h48), and column 7 SHALL carry 'z' (7'h7A).
REQ-024 A digit 0-9 SHALL map to 7'h30+digit, and a digit greater than 9 SHALL map to ERR_CODE.
REQ-025 DONE SHALL last exactly one cycle with Frame_Done=1, Char_Valid=0 and Busy=1.
REQ-026 DONE SHALL then go to IDLE, or re-snapshot and enter SEND if a refresh is pending.
REQ-027 A Refresh arriving in SEND or DONE SHALL set a one-deep pending flag; further Refresh pulses merge into it.
REQ-028 The pending flag SHALL clear when its snapshot is taken.
REQ-029 The snapshot SHALL NOT change during a frame, whatever happens on CH1_BCD/CH2_BCD.
REQ-030 With no downstream stall, a frame SHALL take 16 SEND cycles plus 1 DONE cycle.

Reset
REQ-031 Main_RST_n=0 SHALL immediately force IDLE, index 0, pending 0, snapshots 0, and Char_Valid, Busy, Frame_Done, Char_Code, Char_Row and Char_Col all 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no Frame_Done pulse.
REQ-033 After reset, only a new Refresh SHALL start a frame.

Configuration
REQ-034 Macro FREQ_READOUT_ZERO_BLANK_EN defined: within a row, each leading digit equal to 0 in columns 0-3 SHALL be emitted as SPACE_CODE until the first non-zero or invalid digit. Column 4 is never blanked.
REQ-035 FREQ_READOUT_ZERO_BLANK_EN undefined: all five digits SHALL be emitted literally, including leading '0'.

Verification
REQ-036 Refresh with CH1_BCD=20'h01234, CH2_BCD=20'h00050, Char_Ready held at 1, blanking enabled -> 16 consecutive valid characters " 1234 Hz" then "   50 Hz", followed by Frame_Done exactly one cycle after the last character.
REQ-037 The same stimulus with the macro undefined -> "01234 Hz" then "00050 Hz".
REQ-038 CH1_BCD=20'h00000 with blanking enabled -> "    0 Hz". CH2_BCD=20'h0A123 -> " ?123 Hz".
REQ-039 Char_Ready low for 5 cycles at index 3 while CH1_BCD changes -> Char_Code, Char_Row and Char_Col are held for those 5 cycles, and the stream still shows the original snapshot.
REQ-040 Three Refresh pulses during SEND -> exactly one additional frame, starting directly after DONE.
REQ-041 Main_RST_n pulsed low at index 9 -> all outputs are 0 at once, no Frame_Done, and the block is idle until the next Refresh.
